// File: rtl/trackball_quad_decoder_if.sv
// Signal bundle between one trackball axis (quadrature phases, controls)
// and its decoder front-end. master drives the phases, slave is the decoder.
interface trackball_quad_decoder_if;
  logic       quad_a;
  logic       quad_b;
  logic       flip;
  logic       err_clr;
  logic       cten;
  logic       du;
  logic       err;
  logic [1:0] phase;

  modport master (
    output quad_a, quad_b, flip, err_clr,
    input  cten, du, err, phase
  );

  modport slave (
    input  quad_a, quad_b, flip, err_clr,
    output cten, du, err, phase
  );
endinterface

// File: rtl/trackball_quad_decoder.sv
// Quadrature front-end for one trackball axis: sync, optional glitch filter
// (compile with TRACKBALL_FILTER_EN), Gray-code phase FSM, count strobe/direction.
module trackball_quad_decoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  trackball_quad_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } state_t;

  // Startup settle time: the FSM loads its first state only once the
  // accepted value reflects real input rather than flop reset values.
  localparam int WARM_W = $clog2(FILTER_LEN + 3);
`ifdef TRACKBALL_FILTER_EN
  localparam int WARM = 2 + FILTER_LEN;
`else
  localparam int WARM = 2;
`endif

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   fwd_of = 2'b01;
      2'b01:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b10;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  // ---- sync stage ----
  logic [1:0] s1;
  logic [1:0] s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {bus.quad_a, bus.quad_b};
      s2 <= s1;
    end
  end

  // ---- filter stage ----
  logic [1:0] acc;

`ifdef TRACKBALL_FILTER_EN
  for (genvar i = 0; i < 2; i++) begin : g_flt
    logic       acc_q;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= 1'b0;
        cnt   <= 4'd0;
      end else if (s2[i] == acc_q) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        acc_q <= s2[i];
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end

    assign acc[i] = acc_q;
  end
`else
  assign acc = s2;
`endif

  // ---- phase FSM stage ----
  logic [WARM_W-1:0] warm_cnt;
  logic              rdy;

  assign rdy = (warm_cnt == WARM_W'(WARM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      warm_cnt <= '0;
    else if (!rdy)
      warm_cnt <= warm_cnt + WARM_W'(1);
  end

  state_t state, state_nxt;
  logic   armed, armed_nxt;
  logic   cten_q, cten_nxt;
  logic   du_q, du_nxt;
  logic   err_q, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S00;
      armed  <= 1'b0;
      cten_q <= 1'b1;
      du_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      armed  <= armed_nxt;
      cten_q <= cten_nxt;
      du_q   <= du_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    cten_nxt  = 1'b1;
    du_nxt    = du_q;
    err_nxt   = err_q;

    // Clear first so a same-cycle illegal jump wins.
    if (bus.err_clr)
      err_nxt = 1'b0;

    if (!armed) begin
      if (rdy) begin
        state_nxt = state_t'(acc);
        armed_nxt = 1'b1;
      end
    end else if (acc != state) begin
      state_nxt = state_t'(acc);
      if (acc == fwd_of(state)) begin
        cten_nxt = 1'b0;
        du_nxt   = bus.flip;
      end else if (state == fwd_of(acc)) begin
        cten_nxt = 1'b0;
        du_nxt   = ~bus.flip;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  assign bus.cten  = cten_q;
  assign bus.du    = du_q;
  assign bus.err   = err_q;
  assign bus.phase = state;

endmodule

// File: tb/tb_trackball_quad_decoder.sv
// Directed bench for trackball_quad_decoder: a Gray-index position model
// checked every cycle, plus literal expectations for latency, direction and flags.
module tb_trackball_quad_decoder;

  localparam int FILTER_LEN = 4;
`ifdef TRACKBALL_FILTER_EN
  localparam int FLT = FILTER_LEN;
`else
  localparam int FLT = 0;
`endif
  localparam int WARM = 2 + FLT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trackball_quad_decoder_if bus();

  trackball_quad_decoder #(.FILTER_LEN(FILTER_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_strobe = 0;
  int dut_pos  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Position of a {A,B} value along the forward Gray cycle.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Model: inputs reach the decision point two samples late; a filtered bit
  // moves only after FLT consecutive differing samples; steps are classified
  // by Gray-index difference modulo 4.
  logic [1:0] m_d1 = '0, m_d2 = '0, m_facc = '0, m_cur = '0, m_phase = '0;
  int         m_run [2];
  int         m_edges = 0;
  int         m_step  = 0;
  logic       m_armed = 1'b0;
  logic       m_cten  = 1'b1;
  logic       m_du    = 1'b0;
  logic       m_err   = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_facc = '0; m_phase = '0;
      m_run[0] = 0; m_run[1] = 0; m_edges = 0;
      m_armed = 1'b0; m_cten = 1'b1; m_du = 1'b0; m_err = 1'b0;
    end else begin
      m_cur  = (FLT == 0) ? m_d2 : m_facc;
      m_cten = 1'b1;
      if (bus.err_clr) m_err = 1'b0;
      if (!m_armed) begin
        if (m_edges >= WARM) begin
          m_phase = m_cur;
          m_armed = 1'b1;
        end
      end else if (m_cur != m_phase) begin
        m_step = (gidx(m_cur) - gidx(m_phase) + 4) % 4;
        if (m_step == 1) begin
          m_cten = 1'b0; m_du = bus.flip;
        end else if (m_step == 3) begin
          m_cten = 1'b0; m_du = ~bus.flip;
        end else begin
          m_err = 1'b1;
        end
        m_phase = m_cur;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_d2[i] != m_facc[i]) begin
          m_run[i]++;
          if (m_run[i] >= FLT) begin
            m_facc[i] = m_d2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = {bus.quad_a, bus.quad_b};
      if (m_edges < 1000) m_edges++;
    end
  end

  // Every-cycle comparison, plus the downstream up/down counter.
  initial forever begin
    @(negedge clk);
    chk("cten",  32'(bus.cten),  32'(m_cten));
    chk("du",    32'(bus.du),    32'(m_du));
    chk("err",   32'(bus.err),   32'(m_err));
    chk("phase", 32'(bus.phase), 32'(m_phase));
    if (bus.cten === 1'b0) begin
      n_strobe++;
      dut_pos += bus.du ? -1 : 1;
    end
  end

  task automatic hold(input logic [1:0] ab, input int n);
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.cten === 1'b0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic step_chk(input logic [1:0] ab, input logic exp_du, input string nm);
    int lat;
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    wait_strobe(20 + FLT, lat);
    chk({nm, "_lat"}, lat, 3 + FLT);
    chk({nm, "_du"}, 32'(bus.du), 32'(exp_du));
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1;
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 + FLT) @(negedge clk);
  endtask

  int base_s;
  int base_p;

  initial begin
    bus.quad_a  = 1'b1;
    bus.quad_b  = 1'b1;
    bus.flip    = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 + FLT) @(negedge clk);
    chk("init_phase",   32'(bus.phase), 32'd3);
    chk("init_err",     32'(bus.err),   32'd0);
    chk("init_strobes", n_strobe,       32'd0);

    do_reset(2'b00);
    chk("rst00_phase", 32'(bus.phase), 32'd0);
    base_s = n_strobe;
    base_p = dut_pos;

    // forward, flip=0
    bus.flip = 1'b0;
    step_chk(2'b01, 1'b0, "fw01");
    step_chk(2'b11, 1'b0, "fw11");
    step_chk(2'b10, 1'b0, "fw10");
    step_chk(2'b00, 1'b0, "fw00");
    chk("fw_strobes", n_strobe - base_s, 32'd4);
    chk("fw_pos",     dut_pos - base_p,  32'd4);

    // reverse, flip=1: still counts up
    bus.flip = 1'b1;
    step_chk(2'b10, 1'b0, "rf10");
    step_chk(2'b11, 1'b0, "rf11");
    step_chk(2'b01, 1'b0, "rf01");
    step_chk(2'b00, 1'b0, "rf00");
    chk("rf_pos", dut_pos - base_p, 32'd8);

    // reverse, flip=0: counts down
    bus.flip = 1'b0;
    step_chk(2'b10, 1'b1, "rv10");
    step_chk(2'b11, 1'b1, "rv11");
    step_chk(2'b01, 1'b1, "rv01");
    step_chk(2'b00, 1'b1, "rv00");
    chk("rv_strobes", n_strobe - base_s, 32'd12);
    chk("rv_pos",     dut_pos - base_p,  32'd4);

    // flip alone never strobes
    bus.flip = 1'b1;
    repeat (3) @(negedge clk);
    bus.flip = 1'b0;
    repeat (10) @(negedge clk);
    chk("flip_strobes", n_strobe - base_s, 32'd12);

`ifdef TRACKBALL_FILTER_EN
    // two-cycle glitch on A is rejected, stable change accepted
    hold(2'b10, 2);
    hold(2'b00, 20);
    chk("glitch_strobes", n_strobe - base_s, 32'd12);
    chk("glitch_phase",   32'(bus.phase),    32'd0);
    step_chk(2'b10, 1'b1, "flt10");
    step_chk(2'b00, 1'b0, "flt00");
    base_s = base_s + 2;
`endif

    // illegal jump 00->11
    hold(2'b11, 20);
    chk("jump_err",     32'(bus.err),      32'd1);
    chk("jump_phase",   32'(bus.phase),    32'd3);
    chk("jump_strobes", n_strobe - base_s, 32'd12);

    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(bus.err), 32'd0);

    // jump 11->00 with err_clr on the same edge the jump is seen
    bus.quad_a = 1'b0;
    bus.quad_b = 1'b0;
    repeat (2 + FLT) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("clr_vs_set_err", 32'(bus.err),   32'd1);
    chk("clr_vs_phase",   32'(bus.phase), 32'd0);

    // reset between acceptance and strobe
    base_s = n_strobe;
    bus.quad_a = 1'b0;
    bus.quad_b = 1'b1;
    repeat (2 + FLT) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cten",  32'(bus.cten),  32'd1);
    chk("mid_rst_du",    32'(bus.du),    32'd0);
    chk("mid_rst_err",   32'(bus.err),   32'd0);
    chk("mid_rst_phase", 32'(bus.phase), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15 + FLT) @(negedge clk);
    chk("post_rst_phase",   32'(bus.phase),    32'd1);
    chk("post_rst_strobes", n_strobe - base_s, 32'd0);
    chk("post_rst_err",     32'(bus.err),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
